// File: rtl/sys_ctrl_pkg.sv
// Shared types and constants for the UART command controller.
package sys_ctrl_pkg;

    localparam logic [7:0] CMD_RF_WR   = 8'hAA;
    localparam logic [7:0] CMD_RF_RD   = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

    localparam int OPA_ADDR = 0;
    localparam int OPB_ADDR = 1;

    typedef enum logic [3:0] {
        IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OPA, OPB, FUN, ALU_WAIT, TX_RUN
    } cmd_state_t;

    typedef enum logic [1:0] {
        TX_IDLE, TX_LO, TX_HI
    } tx_state_t;

endpackage

// File: rtl/sys_ctrl_tx_seq.sv
// Result serialiser: sends the low byte when TX is free, and in two-byte mode
// sends the high byte only after TX_BUSY has risen and fallen again.
module sys_ctrl_tx_seq
    import sys_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
)(
    input  logic               CLK,
    input  logic               RST,
    input  logic               start,
    input  logic               two_byte,
    input  logic [2*WIDTH-1:0] data,
    input  logic               abort,
    input  logic               TX_BUSY,
    output logic [WIDTH-1:0]   TX_P_DATA,
    output logic               TX_D_VALID,
    output logic               done
);

    tx_state_t        state;
    logic [WIDTH-1:0] lo_byte;
    logic [WIDTH-1:0] hi_byte;
    logic             two_q;
    logic             seen_busy;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= TX_IDLE;
            lo_byte    <= '0;
            hi_byte    <= '0;
            two_q      <= 1'b0;
            seen_busy  <= 1'b0;
            TX_P_DATA  <= '0;
            TX_D_VALID <= 1'b0;
            done       <= 1'b0;
        end else begin
            TX_D_VALID <= 1'b0;
            done       <= 1'b0;
            if (abort) begin
                state <= TX_IDLE;
            end else begin
                case (state)
                    TX_IDLE: begin
                        if (start) begin
                            lo_byte <= data[WIDTH-1:0];
                            hi_byte <= data[2*WIDTH-1:WIDTH];
                            two_q   <= two_byte;
                            state   <= TX_LO;
                        end
                    end
                    TX_LO: begin
                        if (!TX_BUSY) begin
                            TX_P_DATA  <= lo_byte;
                            TX_D_VALID <= 1'b1;
                            seen_busy  <= 1'b0;
                            if (two_q) begin
                                state <= TX_HI;
                            end else begin
                                done  <= 1'b1;
                                state <= TX_IDLE;
                            end
                        end
                    end
                    TX_HI: begin
                        // The serialiser must first acknowledge the low byte by going busy.
                        if (TX_BUSY) begin
                            seen_busy <= 1'b1;
                        end else if (seen_busy) begin
                            TX_P_DATA  <= hi_byte;
                            TX_D_VALID <= 1'b1;
                            done       <= 1'b1;
                            state      <= TX_IDLE;
                        end
                    end
                    default: state <= TX_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/sys_ctrl_cmd.sv
// Command FSM decoding UART byte frames into RF/ALU accesses and TX results.
// Optional inter-frame watchdog enabled by defining SYS_CTRL_TIMEOUT_EN.
module sys_ctrl_cmd
    import sys_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ADDR  = 4,
    parameter int FUN_W = 4
`ifdef SYS_CTRL_TIMEOUT_EN
    , parameter int TIMEOUT_CYC = 4096
`endif
)(
    input  logic               CLK,
    input  logic               RST,
    input  logic [WIDTH-1:0]   RX_P_DATA,
    input  logic               RX_D_VALID,
    input  logic [WIDTH-1:0]   RdData,
    input  logic               RdData_Valid,
    input  logic [2*WIDTH-1:0] ALU_OUT,
    input  logic               ALU_OUT_VLD,
    input  logic               TX_BUSY,
    output logic               WrEn,
    output logic               RdEn,
    output logic [ADDR-1:0]    Address,
    output logic [WIDTH-1:0]   WrData,
    output logic               ALU_EN,
    output logic [FUN_W-1:0]   ALU_FUN,
    output logic [WIDTH-1:0]   TX_P_DATA,
    output logic               TX_D_VALID
);

    cmd_state_t         state;
    logic [2*WIDTH-1:0] result;
    logic               two_byte;
    logic               tx_start;
    logic               tx_abort;
    logic               tx_done;
    logic               wd_expired;

`ifdef SYS_CTRL_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    logic [WD_W-1:0] wd_cnt;
    cmd_state_t      state_d;

    // Down-counter reloads on every byte and on every state change.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wd_cnt  <= WD_W'(TIMEOUT_CYC - 1);
            state_d <= IDLE;
        end else begin
            state_d <= state;
            if (RX_D_VALID || (state != state_d))
                wd_cnt <= WD_W'(TIMEOUT_CYC - 1);
            else if (wd_cnt != '0)
                wd_cnt <= wd_cnt - WD_W'(1);
        end
    end

    assign wd_expired = (wd_cnt == '0) && (state != IDLE) && (state == state_d);
`else
    assign wd_expired = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            WrEn     <= 1'b0;
            RdEn     <= 1'b0;
            Address  <= '0;
            WrData   <= '0;
            ALU_EN   <= 1'b0;
            ALU_FUN  <= '0;
            result   <= '0;
            two_byte <= 1'b0;
            tx_start <= 1'b0;
            tx_abort <= 1'b0;
        end else begin
            WrEn     <= 1'b0;
            RdEn     <= 1'b0;
            ALU_EN   <= 1'b0;
            tx_start <= 1'b0;
            tx_abort <= 1'b0;
            if (wd_expired) begin
                tx_abort <= (state == TX_RUN);
                state    <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (RX_D_VALID) begin
                            if (RX_P_DATA == WIDTH'(CMD_RF_WR))        state <= WR_ADDR;
                            else if (RX_P_DATA == WIDTH'(CMD_RF_RD))   state <= RD_ADDR;
                            else if (RX_P_DATA == WIDTH'(CMD_ALU_OP))  state <= OPA;
                            else if (RX_P_DATA == WIDTH'(CMD_ALU_NOP)) state <= FUN;
                        end
                    end
                    WR_ADDR: begin
                        if (RX_D_VALID) begin
                            Address <= RX_P_DATA[ADDR-1:0];
                            state   <= WR_DATA;
                        end
                    end
                    WR_DATA: begin
                        if (RX_D_VALID) begin
                            WrData <= RX_P_DATA;
                            WrEn   <= 1'b1;
                            state  <= IDLE;
                        end
                    end
                    RD_ADDR: begin
                        if (RX_D_VALID) begin
                            Address <= RX_P_DATA[ADDR-1:0];
                            RdEn    <= 1'b1;
                            state   <= RD_WAIT;
                        end
                    end
                    RD_WAIT: begin
                        if (RdData_Valid) begin
                            result   <= {{WIDTH{1'b0}}, RdData};
                            two_byte <= 1'b0;
                            tx_start <= 1'b1;
                            state    <= TX_RUN;
                        end
                    end
                    OPA: begin
                        if (RX_D_VALID) begin
                            Address <= ADDR'(OPA_ADDR);
                            WrData  <= RX_P_DATA;
                            WrEn    <= 1'b1;
                            state   <= OPB;
                        end
                    end
                    OPB: begin
                        if (RX_D_VALID) begin
                            Address <= ADDR'(OPB_ADDR);
                            WrData  <= RX_P_DATA;
                            WrEn    <= 1'b1;
                            state   <= FUN;
                        end
                    end
                    FUN: begin
                        if (RX_D_VALID) begin
                            ALU_FUN <= RX_P_DATA[FUN_W-1:0];
                            ALU_EN  <= 1'b1;
                            state   <= ALU_WAIT;
                        end
                    end
                    ALU_WAIT: begin
                        if (ALU_OUT_VLD) begin
                            result   <= ALU_OUT;
                            two_byte <= 1'b1;
                            tx_start <= 1'b1;
                            state    <= TX_RUN;
                        end
                    end
                    TX_RUN: begin
                        // RX bytes arriving here are dropped on purpose; there is no queue.
                        if (tx_done) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    sys_ctrl_tx_seq #(
        .WIDTH(WIDTH)
    ) u_tx_seq (
        .CLK       (CLK),
        .RST       (RST),
        .start     (tx_start),
        .two_byte  (two_byte),
        .data      (result),
        .abort     (tx_abort),
        .TX_BUSY   (TX_BUSY),
        .TX_P_DATA (TX_P_DATA),
        .TX_D_VALID(TX_D_VALID),
        .done      (tx_done)
    );

endmodule

// File: tb/tb_sys_ctrl_cmd.sv
// Directed bench for sys_ctrl_cmd with small RF, ALU and TX responders.
module tb_sys_ctrl_cmd;

    logic        CLK = 1'b0;
    logic        RST;
    logic [7:0]  RX_P_DATA;
    logic        RX_D_VALID;
    logic [7:0]  RdData;
    logic        RdData_Valid;
    logic [15:0] ALU_OUT;
    logic        ALU_OUT_VLD;
    logic        TX_BUSY;
    logic        WrEn;
    logic        RdEn;
    logic [3:0]  Address;
    logic [7:0]  WrData;
    logic        ALU_EN;
    logic [3:0]  ALU_FUN;
    logic [7:0]  TX_P_DATA;
    logic        TX_D_VALID;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mem [16];
    logic [7:0] tx_log [16];
    int tx_n = 0, wr_cnt = 0, rd_cnt = 0, alu_cnt = 0, both_cnt = 0, busy_viol = 0;
    int busy_cnt = 0;
    logic hold_busy = 1'b0;

    always #5 CLK = ~CLK;

    assign TX_BUSY = hold_busy || (busy_cnt != 0);

    sys_ctrl_cmd #(
        .WIDTH(8),
        .ADDR (4),
        .FUN_W(4)
`ifdef SYS_CTRL_TIMEOUT_EN
        , .TIMEOUT_CYC(16)
`endif
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .RX_P_DATA   (RX_P_DATA),
        .RX_D_VALID  (RX_D_VALID),
        .RdData      (RdData),
        .RdData_Valid(RdData_Valid),
        .ALU_OUT     (ALU_OUT),
        .ALU_OUT_VLD (ALU_OUT_VLD),
        .TX_BUSY     (TX_BUSY),
        .WrEn        (WrEn),
        .RdEn        (RdEn),
        .Address     (Address),
        .WrData      (WrData),
        .ALU_EN      (ALU_EN),
        .ALU_FUN     (ALU_FUN),
        .TX_P_DATA   (TX_P_DATA),
        .TX_D_VALID  (TX_D_VALID)
    );

    // Responders: RF, ALU and a TX serialiser that stays busy 3 cycles per byte.
    always @(negedge CLK) begin
        RdData_Valid = 1'b0;
        ALU_OUT_VLD  = 1'b0;
        if (RST) begin
            busy_cnt = 0;
        end else begin
            if (WrEn && RdEn) both_cnt++;
            if (WrEn) begin
                wr_cnt++;
                mem[Address] = WrData;
            end
            if (RdEn) begin
                rd_cnt++;
                RdData       = mem[Address];
                RdData_Valid = 1'b1;
            end
            if (ALU_EN) begin
                alu_cnt++;
                case (ALU_FUN)
                    4'd0:    ALU_OUT = {8'h00, mem[0]} + {8'h00, mem[1]};
                    4'd1:    ALU_OUT = {8'h00, mem[0]} - {8'h00, mem[1]};
                    default: ALU_OUT = {8'h00, mem[0]} * {8'h00, mem[1]};
                endcase
                ALU_OUT_VLD = 1'b1;
            end
            if (TX_D_VALID) begin
                if (TX_BUSY) busy_viol++;
                if (tx_n < 16) tx_log[tx_n] = TX_P_DATA;
                tx_n++;
                busy_cnt = 3;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge CLK);
        RX_P_DATA  = b;
        RX_D_VALID = 1'b1;
        @(negedge CLK);
        RX_D_VALID = 1'b0;
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
        #1;
    endtask

    task automatic wait_tx(input int target, input int budget);
        int k = 0;
        while (tx_n < target && k < budget) begin
            @(negedge CLK);
            k++;
        end
        #1;
        check_eq("tx_wait", 32'(tx_n >= target), 32'd1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_ctl"}, {WrEn, RdEn, ALU_EN, TX_D_VALID}, 4'b0000);
        check_eq({tag, "_addr"}, Address, 4'h0);
        check_eq({tag, "_wdata"}, WrData, 8'h00);
        check_eq({tag, "_fun"}, ALU_FUN, 4'h0);
        check_eq({tag, "_txd"}, TX_P_DATA, 8'h00);
    endtask

    int base_tx, base_wr, base_rd, base_alu;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        RST = 1'b1;
        RX_P_DATA = 8'h00; RX_D_VALID = 1'b0;
        RdData = 8'h00; RdData_Valid = 1'b0;
        ALU_OUT = 16'h0000; ALU_OUT_VLD = 1'b0;
        idle(3);
        check_outputs_zero("reset");
        @(negedge CLK);
        RST = 1'b0;
        idle(2);

        // RF write
        send_byte(8'hAA);
        send_byte(8'h05);
        send_byte(8'h3C);
        check_eq("wr_en", WrEn, 1'b1);
        check_eq("wr_addr", Address, 4'h5);
        check_eq("wr_data", WrData, 8'h3C);
        check_eq("wr_no_rd", RdEn, 1'b0);
        idle(1);
        check_eq("wr_en_one_cycle", WrEn, 1'b0);
        check_eq("wr_count", wr_cnt, 1);

        // RF read back, one byte out
        base_tx = tx_n;
        send_byte(8'hBB);
        send_byte(8'h05);
        check_eq("rd_en", RdEn, 1'b1);
        check_eq("rd_addr", Address, 4'h5);
        wait_tx(base_tx + 1, 40);
        check_eq("rd_tx_byte", tx_log[base_tx], 8'h3C);
        idle(8);
        check_eq("rd_tx_count", tx_n - base_tx, 1);

        // Address wrap: upper bits dropped
        send_byte(8'hAA);
        send_byte(8'hF7);
        send_byte(8'h5A);
        check_eq("wrap_addr", Address, 4'h7);
        check_eq("wrap_wren", WrEn, 1'b1);
        idle(2);

        // ALU add with operands
        base_tx = tx_n; base_wr = wr_cnt;
        send_byte(8'hCC);
        send_byte(8'h07);
        check_eq("opa_wren", WrEn, 1'b1);
        check_eq("opa_addr", Address, 4'h0);
        check_eq("opa_data", WrData, 8'h07);
        send_byte(8'h03);
        check_eq("opb_addr", Address, 4'h1);
        check_eq("opb_data", WrData, 8'h03);
        send_byte(8'h00);
        check_eq("alu_en", ALU_EN, 1'b1);
        check_eq("alu_fun_add", ALU_FUN, 4'h0);
        wait_tx(base_tx + 2, 60);
        check_eq("add_lo", tx_log[base_tx], 8'h0A);
        check_eq("add_hi", tx_log[base_tx + 1], 8'h00);
        check_eq("op_wr_count", wr_cnt - base_wr, 2);
        idle(8);

        // ALU op without operands: subtract
        base_tx = tx_n; base_wr = wr_cnt; base_alu = alu_cnt;
        send_byte(8'hDD);
        send_byte(8'h01);
        check_eq("nop_alu_en", ALU_EN, 1'b1);
        check_eq("nop_fun", ALU_FUN, 4'h1);
        wait_tx(base_tx + 2, 60);
        check_eq("sub_lo", tx_log[base_tx], 8'h04);
        check_eq("sub_hi", tx_log[base_tx + 1], 8'h00);
        check_eq("nop_no_wr", wr_cnt - base_wr, 0);
        check_eq("nop_alu_count", alu_cnt - base_alu, 1);
        idle(8);

        // Junk bytes in IDLE
        base_tx = tx_n; base_wr = wr_cnt; base_rd = rd_cnt; base_alu = alu_cnt;
        send_byte(8'h55);
        send_byte(8'hFF);
        idle(10);
        check_eq("junk_strobes", (wr_cnt - base_wr) + (rd_cnt - base_rd) + (alu_cnt - base_alu) + (tx_n - base_tx), 0);
        check_eq("fun_held", ALU_FUN, 4'h1);

        // Byte arriving while the low byte is blocked by TX_BUSY is dropped
        hold_busy = 1'b1;
        base_tx = tx_n; base_wr = wr_cnt;
        send_byte(8'hBB);
        send_byte(8'h05);
        idle(6);
        send_byte(8'hAA);
        idle(3);
        check_eq("busy_no_tx", tx_n - base_tx, 0);
        hold_busy = 1'b0;
        wait_tx(base_tx + 1, 40);
        check_eq("busy_tx_byte", tx_log[base_tx], 8'h3C);
        idle(6);
        send_byte(8'h07);
        send_byte(8'h11);
        idle(4);
        check_eq("busy_drop_no_wr", wr_cnt - base_wr, 0);

        // Reset mid-command
        base_wr = wr_cnt;
        send_byte(8'hAA);
        send_byte(8'h05);
        @(negedge CLK);
        RST = 1'b1;
        #1;
        check_outputs_zero("midrst");
        idle(2);
        @(negedge CLK);
        RST = 1'b0;
        send_byte(8'h3C);
        idle(4);
        check_eq("midrst_no_wr", wr_cnt - base_wr, 0);

`ifdef SYS_CTRL_TIMEOUT_EN
        base_wr = wr_cnt; base_rd = rd_cnt;
        send_byte(8'hAA);
        idle(24);
        send_byte(8'hBB);
        send_byte(8'h02);
        check_eq("to_rd_en", RdEn, 1'b1);
        check_eq("to_rd_addr", Address, 4'h2);
        idle(20);
        check_eq("to_no_wr", wr_cnt - base_wr, 0);
`endif

        idle(4);
        check_eq("wr_rd_overlap", both_cnt, 0);
        check_eq("tx_while_busy", busy_viol, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
